operand_fetch_engine: RTL and testbench

//  Parametrised successor to the two-port operand fetch path. Accepts a fetch command (status word)
//  via valid/ready, generates NUM_PORTS sequential data-memory addresses per beat, captures the read

---
 rtl/opf_pkg.sv | 20 ++
 rtl/operand_fetch_engine_if.sv | 42 ++++
 rtl/opf_fifo.sv | 54 +++++
 rtl/operand_fetch_engine.sv | 154 +++++++++++++++
 tb/tb_operand_fetch_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/opf_pkg.sv
// Shared types for the operand fetch engine: command modes, FSM states and
// the command field layout.
package opf_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [1:0] {
    ModeNormal = 2'b00,
    ModeBurst  = 2'b01,
    ModeSwap   = 2'b10,
    ModeFlush  = 2'b11
  } opf_mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StDrain = 2'b10
  } opf_state_e;

endpackage

// File: rtl/operand_fetch_engine_if.sv
// Command, data-memory and operand-queue signals of the operand fetch engine.
// OPF_BYPASS_EN adds the write-back bypass inputs.
interface operand_fetch_engine_if #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned STATUS_W  = 6
);
  logic [STATUS_W-1:0]         status;
  logic                        status_valid;
  logic                        status_ready;
  logic                        mem_re;
  logic [NUM_PORTS*ADDR_W-1:0] mem_addr;
  logic [NUM_PORTS*DATA_W-1:0] mem_rdata;
  logic [NUM_PORTS*DATA_W-1:0] op_data;
  logic                        op_valid;
  logic                        op_ready;
  logic                        busy;
`ifdef OPF_BYPASS_EN
  logic                        wb_en;
  logic [ADDR_W-1:0]           wb_addr;
  logic [DATA_W-1:0]           wb_data;

  modport slave (
    input  status, status_valid, mem_rdata, op_ready, wb_en, wb_addr, wb_data,
    output status_ready, mem_re, mem_addr, op_data, op_valid, busy
  );
  modport master (
    output status, status_valid, mem_rdata, op_ready, wb_en, wb_addr, wb_data,
    input  status_ready, mem_re, mem_addr, op_data, op_valid, busy
  );
`else
  modport slave (
    input  status, status_valid, mem_rdata, op_ready,
    output status_ready, mem_re, mem_addr, op_data, op_valid, busy
  );
  modport master (
    output status, status_valid, mem_rdata, op_ready,
    input  status_ready, mem_re, mem_addr, op_data, op_valid, busy
  );
`endif
endinterface

// File: rtl/opf_fifo.sv
// Synchronous FIFO with registered storage and an occupancy count output.
module opf_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_pop;

  assign w_do_pop = i_pop && (r_count != '0);
  assign o_valid  = (r_count != '0);
  assign o_count  = r_count;
  assign o_data   = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (i_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!i_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_fetch_engine.sv
// Operand fetch engine: turns fetch commands into sequential multi-port memory reads and
// queues the captured operand vectors. OPF_BYPASS_EN enables write-back bypass at capture.
module operand_fetch_engine
  import opf_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned STATUS_W   = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   preset,
  operand_fetch_engine_if.slave bus
);
  localparam int unsigned LEN_W  = STATUS_W - MODE_W;
  localparam int unsigned BEAT_W = LEN_W + 1;
  localparam int unsigned VEC_W  = NUM_PORTS * DATA_W;

  opf_state_e                  r_state, w_state_d;
  logic [ADDR_W-1:0]           r_ptr [NUM_PORTS];
  logic [BEAT_W-1:0]           r_remaining, w_remaining_d;
  logic                        r_swap, w_swap_d;
  logic                        r_inflight;
  logic                        r_cap_swap;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                        w_accept, w_issue, w_credit, w_pop, w_op_valid;
  opf_mode_e                   w_mode;
  logic [LEN_W-1:0]            w_len_m1;
  logic [NUM_PORTS*ADDR_W-1:0] w_addr;
  logic [VEC_W-1:0]            w_cap_data, w_push_data;
`ifdef OPF_BYPASS_EN
  logic [NUM_PORTS*ADDR_W-1:0] r_cap_addr;
`endif

  assign w_mode           = opf_mode_e'(bus.status[STATUS_W-1 -: MODE_W]);
  assign w_len_m1         = bus.status[LEN_W-1:0];
  assign bus.status_ready = (r_state == StIdle) && !preset;
  assign w_accept         = bus.status_valid && bus.status_ready;
  // A read in flight has already reserved its FIFO slot.
  assign w_credit         = (32'(w_count) + 32'(r_inflight)) < FIFO_DEPTH;
  assign w_issue          = (r_state == StIssue) && w_credit && !preset;
  assign bus.mem_re       = w_issue;
  assign bus.mem_addr     = w_issue ? w_addr : '0;
  assign bus.busy         = (r_state != StIdle) || r_inflight;
  assign bus.op_valid     = w_op_valid;
  assign w_pop            = w_op_valid && bus.op_ready;

  always_comb begin
    w_addr = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_addr[p*ADDR_W +: ADDR_W] = r_ptr[p];
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_remaining_d = r_remaining;
    w_swap_d      = r_swap;
    case (r_state)
      StIdle: begin
        if (w_accept && (w_mode != ModeFlush)) begin
          w_state_d     = StIssue;
          w_swap_d      = (w_mode == ModeSwap);
          w_remaining_d = (w_mode == ModeBurst) ? BEAT_W'(w_len_m1) + 1'b1 : BEAT_W'(1);
        end
      end
      StIssue: begin
        if (w_issue) begin
          w_remaining_d = r_remaining - 1'b1;
          if (r_remaining == BEAT_W'(1)) begin
            w_state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (r_inflight) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (preset) begin
      r_state     <= StIdle;
      r_remaining <= '0;
      r_swap      <= 1'b0;
      r_inflight  <= 1'b0;
      r_cap_swap  <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_ptr[p] <= ADDR_W'(p);
      end
    end else begin
      r_state     <= w_state_d;
      r_remaining <= w_remaining_d;
      r_swap      <= w_swap_d;
      r_inflight  <= w_issue;
      if (w_issue) begin
        r_cap_swap <= r_swap;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_accept && (w_mode == ModeFlush)) begin
          r_ptr[p] <= ADDR_W'(p);
        end else if (w_issue) begin
          r_ptr[p] <= r_ptr[p] + ADDR_W'(NUM_PORTS);
        end
      end
    end
  end

`ifdef OPF_BYPASS_EN
  always_ff @(posedge clk) begin
    if (preset) begin
      r_cap_addr <= '0;
    end else if (w_issue) begin
      r_cap_addr <= w_addr;
    end
  end
`endif

  always_comb begin
    w_cap_data = bus.mem_rdata;
`ifdef OPF_BYPASS_EN
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.wb_en && (r_cap_addr[p*ADDR_W +: ADDR_W] == bus.wb_addr)) begin
        w_cap_data[p*DATA_W +: DATA_W] = bus.wb_data;
      end
    end
`endif
    w_push_data = w_cap_data;
    if (r_cap_swap) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        w_push_data[(NUM_PORTS-1-p)*DATA_W +: DATA_W] = w_cap_data[p*DATA_W +: DATA_W];
      end
    end
  end

  opf_fifo #(
    .WIDTH(VEC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (preset),
    .i_push     (r_inflight),
    .i_push_data(w_push_data),
    .i_pop      (w_pop),
    .o_data     (bus.op_data),
    .o_valid    (w_op_valid),
    .o_count    (w_count)
  );

endmodule

// File: tb/tb_operand_fetch_engine.sv
// Scoreboard bench for operand_fetch_engine: expected operand vectors are queued as commands
// are issued and compared as the FIFO head is consumed.
module tb_operand_fetch_engine;
  import opf_pkg::*;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned NUM_PORTS  = 2;
  localparam int unsigned STATUS_W   = 6;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned VEC_W      = NUM_PORTS * DATA_W;

  logic clk = 1'b0;
  logic preset;

  operand_fetch_engine_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PORTS(NUM_PORTS), .STATUS_W(STATUS_W)
  ) bus ();

  operand_fetch_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PORTS(NUM_PORTS), .STATUS_W(STATUS_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .preset(preset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int re_cnt   = 0;
  int unsigned m_base = 0;
  logic [VEC_W-1:0] exp_q[$];

  function automatic logic [DATA_W-1:0] m_val(input logic [ADDR_W-1:0] a);
    return 16'hA500 ^ {a, 3'b000, a, 3'b011};
  endfunction

  function automatic logic [NUM_PORTS*ADDR_W-1:0] model_addr(input int unsigned base);
    logic [NUM_PORTS*ADDR_W-1:0] v;
    v = '0;
    for (int p = 0; p < NUM_PORTS; p++) v[p*ADDR_W +: ADDR_W] = ADDR_W'((base + p) % 32);
    return v;
  endfunction

  function automatic logic [VEC_W-1:0] model_vec(input int unsigned base, input bit swap);
    logic [VEC_W-1:0] v;
    int unsigned slot;
    v = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      slot = swap ? (NUM_PORTS - 1 - p) : p;
      v[slot*DATA_W +: DATA_W] = m_val(ADDR_W'((base + p) % 32));
    end
    return v;
  endfunction

  // Data memory with one-cycle read latency; junk when not reading.
  always @(posedge clk) begin
    if (bus.mem_re) re_cnt <= re_cnt + 1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.mem_rdata[p*DATA_W +: DATA_W] <=
        bus.mem_re ? m_val(bus.mem_addr[p*ADDR_W +: ADDR_W]) : 16'hDEAD;
    end
  end

  task automatic send_cmd(input logic [1:0] mode, input logic [3:0] len, input bit push_exp);
    int beats;
    logic [NUM_PORTS*ADDR_W-1:0] ea;
    @(negedge clk);
    bus.status       = {mode, len};
    bus.status_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.status_ready; i++) @(negedge clk);
    checks++;
    if (bus.status_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready got=%b want=1", bus.status_ready);
    end
    @(posedge clk);
    #1;
    bus.status_valid = 1'b0;
    if (mode == 2'b11) begin
      m_base = 0;
    end else begin
      beats = (mode == 2'b01) ? int'(len) + 1 : 1;
      ea = model_addr(m_base);
      for (int b = 0; b < beats; b++) begin
        if (push_exp) exp_q.push_back(model_vec(m_base, mode == 2'b10));
        m_base = (m_base + NUM_PORTS) % 32;
      end
      @(negedge clk);
      checks++;
      if (bus.mem_re !== 1'b1 || bus.mem_addr !== ea) begin
        failures++;
        $display("FAIL first_beat re=%b addr=%h want re=1 addr=%h", bus.mem_re, bus.mem_addr, ea);
      end
    end
  endtask

  // Compare each head at negedge, then pop exactly that entry on the next edge.
  task automatic drain(input int n);
    int got;
    logic [VEC_W-1:0] e;
    got = 0;
    bus.op_ready = 1'b0;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      bus.op_ready = 1'b0;
      if (bus.op_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL op_unexpected got=%h want=<none>", bus.op_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.op_data !== e) begin
            failures++;
            $display("FAIL op_data got=%h want=%h", bus.op_data, e);
          end
        end
        got++;
        bus.op_ready = 1'b1;
      end
    end
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL drain_count got=%0d want=%0d", got, n);
    end
    @(posedge clk);
    #1;
    bus.op_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    @(negedge clk);
    while (bus.busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_timeout busy=%b want=0", bus.busy);
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.op_valid, bus.busy, bus.mem_re, bus.status_ready} !== 4'b0000 ||
        bus.mem_addr !== '0) begin
      failures++;
      $display("FAIL reset_outs v/b/re/rdy=%b%b%b%b addr=%h want 0000 addr=0",
               bus.op_valid, bus.busy, bus.mem_re, bus.status_ready, bus.mem_addr);
    end
    preset = 1'b0;
    m_base = 0;
    @(negedge clk);
    checks++;
    if (bus.status_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b want=1", bus.status_ready);
    end
  endtask

  task automatic test_normal();
    send_cmd(2'b00, 4'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.op_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_c2 op_valid=%b want=0", bus.op_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.op_valid !== 1'b1 || bus.op_data !== exp_q[0]) begin
      failures++;
      $display("FAIL latency_c3 op_valid=%b data=%h want 1 %h", bus.op_valid, bus.op_data,
               exp_q[0]);
    end
    drain(1);
    wait_idle();
  endtask

  task automatic test_burst_backpressure();
    int r0;
    r0 = re_cnt;
    send_cmd(2'b01, 4'd5, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (re_cnt - r0 != FIFO_DEPTH || bus.mem_re !== 1'b0 || bus.busy !== 1'b1 ||
        bus.op_valid !== 1'b1) begin
      failures++;
      $display("FAIL burst_stall beats=%0d re=%b busy=%b valid=%b want %0d 0 1 1",
               re_cnt - r0, bus.mem_re, bus.busy, bus.op_valid, FIFO_DEPTH);
    end
    drain(6);
    wait_idle();
    checks++;
    if (bus.op_valid !== 1'b0) begin
      failures++;
      $display("FAIL burst_empty op_valid=%b want=0", bus.op_valid);
    end
    // Follow-up read confirms pointer advance over all six beats.
    send_cmd(2'b00, 4'h0, 1'b1);
    drain(1);
    wait_idle();
  endtask

  task automatic test_swap();
    send_cmd(2'b11, 4'h0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_re !== 1'b0) begin
      failures++;
      $display("FAIL flush_noread busy=%b re=%b want 0 0", bus.busy, bus.mem_re);
    end
    send_cmd(2'b10, 4'h0, 1'b1);
    drain(1);
    wait_idle();
  endtask

  task automatic test_wrap_flush();
    send_cmd(2'b11, 4'h0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      send_cmd(2'b00, 4'h0, 1'b1);
      drain(1);
      wait_idle();
    end
    send_cmd(2'b00, 4'h0, 1'b1);
    drain(1);
    wait_idle();
    send_cmd(2'b11, 4'h0, 1'b1);
    send_cmd(2'b00, 4'h0, 1'b1);
    drain(1);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int re_seen, last, got;
    logic [VEC_W-1:0] e;
    send_cmd(2'b11, 4'h0, 1'b1);
    send_cmd(2'b01, 4'd7, 1'b1);
    re_seen = 1;
    last    = 1;
    got     = 0;
    for (int i = 2; i < 40 && got < 8; i++) begin
      @(negedge clk);
      bus.op_ready = 1'b0;
      if (bus.mem_re) begin
        re_seen++;
        last = i;
      end
      if (bus.op_valid) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (bus.op_data !== e) begin
          failures++;
          $display("FAIL b2b_data got=%h want=%h", bus.op_data, e);
        end
        got++;
        bus.op_ready = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.op_ready = 1'b0;
    checks++;
    if (re_seen != 8 || last != 8 || got != 8) begin
      failures++;
      $display("FAIL b2b_rate beats=%0d last=%0d got=%0d want 8 8 8", re_seen, last, got);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_burst();
    send_cmd(2'b01, 4'd7, 1'b0);
    @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.op_valid, bus.busy, bus.mem_re, bus.status_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_outs v/b/re/rdy=%b%b%b%b want 0000",
               bus.op_valid, bus.busy, bus.mem_re, bus.status_ready);
    end
    preset = 1'b0;
    m_base = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.op_valid !== 1'b0 || bus.busy !== 1'b0 || bus.status_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_late valid=%b busy=%b rdy=%b want 0 0 1",
               bus.op_valid, bus.busy, bus.status_ready);
    end
    send_cmd(2'b00, 4'h0, 1'b1);
    drain(1);
    wait_idle();
  endtask

`ifdef OPF_BYPASS_EN
  task automatic test_bypass();
    send_cmd(2'b11, 4'h0, 1'b1);
    send_cmd(2'b00, 4'h0, 1'b0);
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd0;
    bus.wb_data = 16'hBEEF;
    exp_q.push_back({m_val(5'd1), 16'hBEEF});
    @(posedge clk);
    #1;
    bus.wb_en = 1'b0;
    drain(1);
    wait_idle();
  endtask
`endif

  initial begin
    preset           = 1'b1;
    bus.status       = '0;
    bus.status_valid = 1'b0;
    bus.op_ready     = 1'b0;
`ifdef OPF_BYPASS_EN
    bus.wb_en   = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
`endif
    test_reset();
    test_normal();
    test_burst_backpressure();
    test_swap();
    test_wrap_flush();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef OPF_BYPASS_EN
    test_bypass();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
